// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encodings (issued by the RS) and the data types
// passed between the ALU pipeline registers and its combinational core.
package alu_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned ROB_W = 5;

    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_LUI   = 6'd1;
    localparam logic [5:0] OP_AUIPC = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_JALR  = 6'd4;
    localparam logic [5:0] OP_BEQ   = 6'd5;
    localparam logic [5:0] OP_BNE   = 6'd6;
    localparam logic [5:0] OP_BLT   = 6'd7;
    localparam logic [5:0] OP_BGE   = 6'd8;
    localparam logic [5:0] OP_BLTU  = 6'd9;
    localparam logic [5:0] OP_BGEU  = 6'd10;
    localparam logic [5:0] OP_LB    = 6'd11;
    localparam logic [5:0] OP_LH    = 6'd12;
    localparam logic [5:0] OP_LW    = 6'd13;
    localparam logic [5:0] OP_LBU   = 6'd14;
    localparam logic [5:0] OP_LHU   = 6'd15;
    localparam logic [5:0] OP_SB    = 6'd16;
    localparam logic [5:0] OP_SH    = 6'd17;
    localparam logic [5:0] OP_SW    = 6'd18;
    localparam logic [5:0] OP_ADDI  = 6'd19;
    localparam logic [5:0] OP_SLTI  = 6'd20;
    localparam logic [5:0] OP_SLTIU = 6'd21;
    localparam logic [5:0] OP_XORI  = 6'd22;
    localparam logic [5:0] OP_ORI   = 6'd23;
    localparam logic [5:0] OP_ANDI  = 6'd24;
    localparam logic [5:0] OP_SLLI  = 6'd25;
    localparam logic [5:0] OP_SRLI  = 6'd26;
    localparam logic [5:0] OP_SRAI  = 6'd27;
    localparam logic [5:0] OP_ADD   = 6'd28;
    localparam logic [5:0] OP_SUB   = 6'd29;
    localparam logic [5:0] OP_SLL   = 6'd30;
    localparam logic [5:0] OP_SLT   = 6'd31;
    localparam logic [5:0] OP_SLTU  = 6'd32;
    localparam logic [5:0] OP_XOR   = 6'd33;
    localparam logic [5:0] OP_SRL   = 6'd34;
    localparam logic [5:0] OP_SRA   = 6'd35;
    localparam logic [5:0] OP_OR    = 6'd36;
    localparam logic [5:0] OP_AND   = 6'd37;

    typedef struct packed {
        logic             valid;
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  v1;
        logic [XLEN-1:0]  v2;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [ROB_W-1:0] rob_id;
    } stage_a_t;

    // Loads and stores share the opcode space but belong to the LSU.
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return ((op >= OP_LUI) && (op <= OP_BGEU)) ||
               ((op >= OP_ADDI) && (op <= OP_AND));
    endfunction

    function automatic logic is_itype(input logic [OP_W-1:0] op);
        return (op >= OP_ADDI) && (op <= OP_SRAI);
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational execute datapath producing the rd value,
// the control-transfer decision and the redirect target for one op.
module alu_core
    import alu_pkg::*;
(
    input  logic [OP_W-1:0] i_op,
    input  logic [XLEN-1:0] i_v1,
    input  logic [XLEN-1:0] i_v2,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    output logic [XLEN-1:0] o_result,
    output logic            o_jump,
    output logic [XLEN-1:0] o_target
);

    logic [XLEN-1:0] w_op2;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_diff;
    logic            w_lt_s;
    logic            w_lt_u;
    logic            w_eq;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_plus_imm;
    logic [XLEN-1:0] w_jalr_sum;

    // Branches are not I-type, so their comparisons see V2 here.
    assign w_op2         = is_itype(i_op) ? i_imm : i_v2;
    assign w_shamt       = w_op2[4:0];
    assign w_sum         = i_v1 + w_op2;
    assign w_diff        = i_v1 - w_op2;
    assign w_lt_s        = $signed(i_v1) < $signed(w_op2);
    assign w_lt_u        = i_v1 < w_op2;
    assign w_eq          = (i_v1 == w_op2);
    assign w_pc_plus4    = i_pc + 32'd4;
    assign w_pc_plus_imm = i_pc + i_imm;
    assign w_jalr_sum    = i_v1 + i_imm;

    // Opcode decode into result, jump decision and redirect target.
    always_comb begin
        o_result = 32'd0;
        o_jump   = 1'b0;
        o_target = w_pc_plus4;
        case (i_op)
            OP_LUI:   o_result = i_imm;
            OP_AUIPC: o_result = w_pc_plus_imm;
            OP_JAL: begin
                o_result = w_pc_plus4;
                o_target = w_pc_plus_imm;
                o_jump   = 1'b1;
            end
            OP_JALR: begin
                o_result = w_pc_plus4;
                o_target = {w_jalr_sum[XLEN-1:1], 1'b0};
                o_jump   = 1'b1;
            end
            OP_BEQ: begin
                o_target = w_pc_plus_imm;
                o_jump   = w_eq;
            end
            OP_BNE: begin
                o_target = w_pc_plus_imm;
                o_jump   = !w_eq;
            end
            OP_BLT: begin
                o_target = w_pc_plus_imm;
                o_jump   = w_lt_s;
            end
            OP_BGE: begin
                o_target = w_pc_plus_imm;
                o_jump   = !w_lt_s;
            end
            OP_BLTU: begin
                o_target = w_pc_plus_imm;
                o_jump   = w_lt_u;
            end
            OP_BGEU: begin
                o_target = w_pc_plus_imm;
                o_jump   = !w_lt_u;
            end
            OP_ADDI, OP_ADD:   o_result = w_sum;
            OP_SUB:            o_result = w_diff;
            OP_SLTI, OP_SLT:   o_result = {31'd0, w_lt_s};
            OP_SLTIU, OP_SLTU: o_result = {31'd0, w_lt_u};
            OP_XORI, OP_XOR:   o_result = i_v1 ^ w_op2;
            OP_ORI, OP_OR:     o_result = i_v1 | w_op2;
            OP_ANDI, OP_AND:   o_result = i_v1 & w_op2;
            OP_SLLI, OP_SLL:   o_result = i_v1 << w_shamt;
            OP_SRLI, OP_SRL:   o_result = i_v1 >> w_shamt;
            OP_SRAI, OP_SRA:   o_result = $unsigned($signed(i_v1) >>> w_shamt);
            default: begin
                o_result = 32'd0;
                o_jump   = 1'b0;
                o_target = w_pc_plus4;
            end
        endcase
    end

endmodule

// File: rtl/alu.sv
// alu: two-stage execute unit. Stage A captures the issued op, stage B
// registers the broadcast computed by alu_core. Freeze, flush and reset control live here.
module alu
    import alu_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic [OP_W-1:0]  inst_name_in,
    input  logic [XLEN-1:0]  V1_in,
    input  logic [XLEN-1:0]  V2_in,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [XLEN-1:0]  imm_in,
    input  logic [ROB_W-1:0] rob_id_in,
    input  logic             rollback_flag_in,
    output logic             valid_out,
    output logic [XLEN-1:0]  result_out,
    output logic [ROB_W-1:0] rob_id_out,
    output logic             jump_flag_out,
    output logic [XLEN-1:0]  target_pc_out
);

    if (STAGES != 2) begin : g_stages_check
        $error("alu: only STAGES=2 is supported");
    end

    stage_a_t         r_a;
    logic             r_valid;
    logic [XLEN-1:0]  r_result;
    logic [ROB_W-1:0] r_rob_id;
    logic             r_jump;
    logic [XLEN-1:0]  r_target;

    logic [XLEN-1:0]  w_result;
    logic             w_jump;
    logic [XLEN-1:0]  w_target;

    // Stage A: capture the issued op; a flush drops whatever is presented.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_a <= '0;
        end else if (rdy_in) begin
            if (rollback_flag_in) begin
                r_a.valid <= 1'b0;
                r_a.op    <= OP_NOP;
            end else begin
                r_a.valid  <= is_alu_op(inst_name_in);
                r_a.op     <= inst_name_in;
                r_a.v1     <= V1_in;
                r_a.v2     <= V2_in;
                r_a.pc     <= pc_in;
                r_a.imm    <= imm_in;
                r_a.rob_id <= rob_id_in;
            end
        end
    end

    alu_core u_core (
        .i_op     (r_a.op),
        .i_v1     (r_a.v1),
        .i_v2     (r_a.v2),
        .i_pc     (r_a.pc),
        .i_imm    (r_a.imm),
        .o_result (w_result),
        .o_jump   (w_jump),
        .o_target (w_target)
    );

    // Stage B: register the broadcast; data fields hold between broadcasts.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_valid  <= 1'b0;
            r_result <= 32'd0;
            r_rob_id <= 5'd0;
            r_jump   <= 1'b0;
            r_target <= 32'd0;
        end else if (rdy_in) begin
            if (rollback_flag_in) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_a.valid;
                if (r_a.valid) begin
                    r_result <= w_result;
                    r_rob_id <= r_a.rob_id;
                    r_jump   <= w_jump;
                    r_target <= w_target;
                end
            end
        end
    end

    assign valid_out     = r_valid;
    assign result_out    = r_result;
    assign rob_id_out    = r_rob_id;
    assign jump_flag_out = r_jump;
    assign target_pc_out = r_target;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vectors for the two-stage ALU, checked every cycle against
// an in-flight-list model plus hand-computed literal expectations.
module tb_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic [5:0]  inst = OP_NOP;
    logic [31:0] v1 = 32'd0, v2 = 32'd0, pc_i = 32'd0, imm_i = 32'd0;
    logic [4:0]  rob_i = 5'd0;
    logic        rollback = 1'b0;

    logic        valid_o, jump_o;
    logic [31:0] result_o, target_o;
    logic [4:0]  rob_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu #(.STAGES(2)) dut (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .inst_name_in(inst),
        .V1_in(v1), .V2_in(v2), .pc_in(pc_i), .imm_in(imm_i),
        .rob_id_in(rob_i), .rollback_flag_in(rollback),
        .valid_out(valid_o), .result_out(result_o), .rob_id_out(rob_o),
        .jump_flag_out(jump_o), .target_pc_out(target_o)
    );

    typedef struct {
        logic [31:0] result;
        logic        jump;
        logic [31:0] target;
    } res_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a, b, pc, imm;
        logic [4:0]  rob;
        int          left;
    } op_t;

    function automatic bit ref_known(input logic [5:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE,
            OP_BLTU, OP_BGEU, OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI,
            OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI, OP_ADD, OP_SUB, OP_SLL, OP_SLT,
            OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic res_t ref_exec(input logic [5:0] op,
                                      input logic [31:0] a, b, pc, imm);
        res_t r;
        int   sh_r, sh_i;
        sh_r = int'(b % 32'd32);
        sh_i = int'(imm % 32'd32);
        r.result = 32'd0; r.jump = 1'b0; r.target = pc + 32'd4;
        case (op)
            OP_LUI:   r.result = imm;
            OP_AUIPC: r.result = pc + imm;
            OP_JAL:   begin r.result = pc + 32'd4; r.target = pc + imm; r.jump = 1'b1; end
            OP_JALR:  begin r.result = pc + 32'd4; r.target = (a + imm) & 32'hFFFF_FFFE; r.jump = 1'b1; end
            OP_BEQ:   begin r.target = pc + imm; r.jump = (a == b); end
            OP_BNE:   begin r.target = pc + imm; r.jump = (a != b); end
            OP_BLT:   begin r.target = pc + imm; r.jump = ($signed(a) < $signed(b)); end
            OP_BGE:   begin r.target = pc + imm; r.jump = ($signed(a) >= $signed(b)); end
            OP_BLTU:  begin r.target = pc + imm; r.jump = (a < b); end
            OP_BGEU:  begin r.target = pc + imm; r.jump = (a >= b); end
            OP_ADDI:  r.result = a + imm;
            OP_SLTI:  r.result = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            OP_SLTIU: r.result = (a < imm) ? 32'd1 : 32'd0;
            OP_XORI:  r.result = a ^ imm;
            OP_ORI:   r.result = a | imm;
            OP_ANDI:  r.result = a & imm;
            OP_SLLI:  r.result = a << sh_i;
            OP_SRLI:  r.result = a >> sh_i;
            OP_SRAI:  r.result = $unsigned($signed(a) >>> sh_i);
            OP_ADD:   r.result = a + b;
            OP_SUB:   r.result = a - b;
            OP_SLL:   r.result = a << sh_r;
            OP_SLT:   r.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU:  r.result = (a < b) ? 32'd1 : 32'd0;
            OP_XOR:   r.result = a ^ b;
            OP_SRL:   r.result = a >> sh_r;
            OP_SRA:   r.result = $unsigned($signed(a) >>> sh_r);
            OP_OR:    r.result = a | b;
            OP_AND:   r.result = a & b;
            default:  r.result = 32'd0;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model state: ops in flight, each with enabled edges left until broadcast.
    op_t         inflight[$];
    logic        m_valid = 1'b0, m_jump = 1'b0;
    logic [31:0] m_result = 32'd0, m_target = 32'd0;
    logic [4:0]  m_rob = 5'd0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                inflight.delete();
                m_valid = 1'b0; m_jump = 1'b0; m_result = 32'd0;
                m_target = 32'd0; m_rob = 5'd0;
            end else if (rdy) begin
                if (rollback) begin
                    inflight.delete();
                    m_valid = 1'b0;
                end else begin
                    op_t  keep[$];
                    res_t r;
                    m_valid = 1'b0;
                    foreach (inflight[k]) begin
                        op_t e;
                        e = inflight[k];
                        e.left--;
                        if (e.left == 0) begin
                            r = ref_exec(e.op, e.a, e.b, e.pc, e.imm);
                            m_valid = 1'b1; m_result = r.result; m_jump = r.jump;
                            m_target = r.target; m_rob = e.rob;
                        end else begin
                            keep.push_back(e);
                        end
                    end
                    inflight = keep;
                    if (ref_known(inst))
                        inflight.push_back('{op: inst, a: v1, b: v2, pc: pc_i,
                                             imm: imm_i, rob: rob_i, left: 1});
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("model_valid",  {31'd0, valid_o}, {31'd0, m_valid});
            chk("model_result", result_o, m_result);
            chk("model_rob",    {27'd0, rob_o}, {27'd0, m_rob});
            chk("model_jump",   {31'd0, jump_o}, {31'd0, m_jump});
            chk("model_target", target_o, m_target);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, b, pc, imm,
                         input logic [4:0] rob);
        inst = op; v1 = a; v2 = b; pc_i = pc; imm_i = imm; rob_i = rob;
        tick();
        inst = OP_NOP;
    endtask

    task automatic chk_out(input string name, input logic vld,
                           input logic [31:0] res, input logic [4:0] rob);
        chk({name, "_valid"}, {31'd0, valid_o}, {31'd0, vld});
        if (vld) begin
            chk({name, "_result"}, result_o, res);
            chk({name, "_rob"}, {27'd0, rob_o}, {27'd0, rob});
        end
    endtask

    op_t  vecs[$];
    res_t pr;

    initial begin
        // Pin the model against hand-computed values.
        pr = ref_exec(OP_ADD, 32'd5, 32'd7, 32'd0, 32'd0);             chk("pin_add", pr.result, 32'd12);
        pr = ref_exec(OP_SUB, 32'd0, 32'd1, 32'd0, 32'd0);             chk("pin_sub", pr.result, 32'hFFFF_FFFF);
        pr = ref_exec(OP_SRAI, 32'h8000_0000, 32'd0, 32'd0, 32'd4);    chk("pin_srai", pr.result, 32'hF800_0000);
        pr = ref_exec(OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0);    chk("pin_sltu", pr.result, 32'd1);
        pr = ref_exec(OP_JALR, 32'h1003, 32'd0, 32'h100, 32'd4);
        chk("pin_jalr_res", pr.result, 32'h104); chk("pin_jalr_tgt", pr.target, 32'h1006);
        chk("pin_jalr_jmp", {31'd0, pr.jump}, 32'd1);
        pr = ref_exec(OP_BNE, 32'd9, 32'd9, 32'h20, 32'd8);
        chk("pin_bne_jmp", {31'd0, pr.jump}, 32'd0); chk("pin_bne_tgt", pr.target, 32'h28);
        pr = ref_exec(OP_SLL, 32'd1, 32'd33, 32'd0, 32'd0);            chk("pin_sll33", pr.result, 32'd2);
        pr = ref_exec(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);     chk("pin_blt", {31'd0, pr.jump}, 32'd1);

        // Reset state.
        tick(); tick();
        chk_out("reset", 1'b0, 32'd0, 5'd0);
        chk("reset_result", result_o, 32'd0);
        chk("reset_target", target_o, 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // Basic ADD latency and single-cycle strobe.
        issue(OP_ADD, 32'd5, 32'd7, 32'h0, 32'd0, 5'd3);
        tick();
        chk_out("add", 1'b1, 32'd12, 5'd3);
        chk("add_jump", {31'd0, jump_o}, 32'd0);
        tick();
        chk_out("add_after", 1'b0, 32'd0, 5'd0);

        // Back-to-back throughput.
        issue(OP_SUB,  32'd0, 32'd1, 32'h0, 32'd0, 5'd1);
        issue(OP_SRAI, 32'h8000_0000, 32'd0, 32'h0, 32'd4, 5'd2);
        chk_out("b2b_sub", 1'b1, 32'hFFFF_FFFF, 5'd1);
        issue(OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'd0, 5'd4);
        chk_out("b2b_srai", 1'b1, 32'hF800_0000, 5'd2);
        tick();
        chk_out("b2b_sltu", 1'b1, 32'd1, 5'd4);
        tick();
        chk_out("b2b_end", 1'b0, 32'd0, 5'd0);

        // Control transfers.
        issue(OP_JALR, 32'h1003, 32'd0, 32'h100, 32'd4, 5'd5);
        issue(OP_BNE, 32'd9, 32'd9, 32'h20, 32'd8, 5'd6);
        chk_out("jalr", 1'b1, 32'h104, 5'd5);
        chk("jalr_target", target_o, 32'h1006);
        chk("jalr_jump", {31'd0, jump_o}, 32'd1);
        tick();
        chk_out("bne", 1'b1, 32'd0, 5'd6);
        chk("bne_target", target_o, 32'h28);
        chk("bne_jump", {31'd0, jump_o}, 32'd0);
        tick();

        // Opcode sweep, including non-ALU opcodes that must not broadcast.
        vecs.push_back('{OP_LUI,   32'd0, 32'd0, 32'h0, 32'h1234_5000, 5'd7, 0});
        vecs.push_back('{OP_AUIPC, 32'd0, 32'd0, 32'h1000, 32'h2000, 5'd8, 0});
        vecs.push_back('{OP_JAL,   32'd0, 32'd0, 32'h200, 32'hFFFF_FFF0, 5'd9, 0});
        vecs.push_back('{OP_BEQ,   32'd3, 32'd3, 32'h300, 32'h10, 5'd10, 0});
        vecs.push_back('{OP_BLT,   32'hFFFF_FFFF, 32'd1, 32'h40, 32'h8, 5'd11, 0});
        vecs.push_back('{OP_BLTU,  32'hFFFF_FFFF, 32'd1, 32'h40, 32'h8, 5'd12, 0});
        vecs.push_back('{OP_BGE,   32'h8000_0000, 32'd0, 32'h40, 32'h8, 5'd13, 0});
        vecs.push_back('{OP_BGEU,  32'd5, 32'd5, 32'h40, 32'hC, 5'd14, 0});
        vecs.push_back('{OP_LW,    32'd1, 32'd2, 32'h44, 32'd0, 5'd15, 0});
        vecs.push_back('{OP_SLT,   32'hFFFF_FFFE, 32'd2, 32'h48, 32'd0, 5'd16, 0});
        vecs.push_back('{OP_SLTI,  32'd5, 32'd0, 32'h4C, 32'hFFFF_FFFF, 5'd17, 0});
        vecs.push_back('{OP_SLTIU, 32'd5, 32'd0, 32'h4C, 32'hFFFF_FFFF, 5'd18, 0});
        vecs.push_back('{OP_SLL,   32'd1, 32'd33, 32'h50, 32'd0, 5'd19, 0});
        vecs.push_back('{OP_SRL,   32'h8000_0000, 32'd31, 32'h54, 32'd0, 5'd20, 0});
        vecs.push_back('{6'd63,    32'd1, 32'd1, 32'h58, 32'd1, 5'd21, 0});
        vecs.push_back('{OP_SRA,   32'h8000_0000, 32'd31, 32'h5C, 32'd0, 5'd22, 0});
        vecs.push_back('{OP_SLLI,  32'd3, 32'd0, 32'h60, 32'd4, 5'd23, 0});
        vecs.push_back('{OP_SRLI,  32'hF0, 32'd0, 32'h64, 32'd4, 5'd24, 0});
        vecs.push_back('{OP_ADDI,  32'd10, 32'd0, 32'h68, 32'hFFFF_FFFF, 5'd25, 0});
        vecs.push_back('{OP_XORI,  32'hFF00, 32'd0, 32'h6C, 32'h0FF0, 5'd26, 0});
        vecs.push_back('{OP_ORI,   32'hF000, 32'd0, 32'h70, 32'h000F, 5'd27, 0});
        vecs.push_back('{OP_ANDI,  32'hFFFF, 32'd0, 32'h74, 32'h0F0F, 5'd28, 0});
        vecs.push_back('{OP_OR,    32'h0A, 32'h50, 32'h78, 32'd0, 5'd29, 0});
        vecs.push_back('{OP_AND,   32'h0C, 32'h0A, 32'h7C, 32'd0, 5'd30, 0});
        foreach (vecs[k])
            issue(vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].pc, vecs[k].imm, vecs[k].rob);
        tick(); tick();

        // Flush drops the in-flight op and the one presented with it.
        issue(OP_ADD, 32'd1, 32'd2, 32'h0, 32'd0, 5'd3);
        rollback = 1'b1;
        issue(OP_ADD, 32'd3, 32'd4, 32'h0, 32'd0, 5'd4);
        rollback = 1'b0;
        chk_out("rollback_drop", 1'b0, 32'd0, 5'd0);
        issue(OP_ADD, 32'd20, 32'd22, 32'h0, 32'd0, 5'd7);
        chk_out("rollback_drop2", 1'b0, 32'd0, 5'd0);
        tick();
        chk_out("after_rollback", 1'b1, 32'd42, 5'd7);
        tick();

        // Flush while frozen is ignored.
        issue(OP_SUB, 32'd50, 32'd8, 32'h0, 32'd0, 5'd8);
        rdy = 1'b0; rollback = 1'b1;
        tick();
        rdy = 1'b1; rollback = 1'b0;
        tick();
        chk_out("frozen_rollback", 1'b1, 32'd42, 5'd8);
        tick();

        // Freeze for three cycles delays the broadcast by three cycles.
        issue(OP_XOR, 32'hF0F0, 32'h0FF0, 32'h40, 32'd0, 5'd9);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out("freeze_hold", 1'b0, 32'd0, 5'd0);
        end
        rdy = 1'b1;
        tick();
        chk_out("freeze_release", 1'b1, 32'hFF00, 5'd9);
        chk("freeze_target", target_o, 32'h44);
        tick();
        chk_out("freeze_after", 1'b0, 32'd0, 5'd0);

        // Freeze while a broadcast is showing holds it.
        issue(OP_ADD, 32'd100, 32'd1, 32'h0, 32'd0, 5'd10);
        tick();
        rdy = 1'b0;
        tick();
        chk_out("freeze_valid_hold", 1'b1, 32'd101, 5'd10);
        rdy = 1'b1;
        tick();
        chk_out("freeze_valid_end", 1'b0, 32'd0, 5'd0);

        // Asynchronous reset with two ops in flight.
        issue(OP_ADD, 32'd1, 32'd1, 32'h80, 32'd0, 5'd11);
        issue(OP_JAL, 32'd0, 32'd0, 32'h90, 32'h10, 5'd12);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_valid",  {31'd0, valid_o}, 32'd0);
        chk("areset_result", result_o, 32'd0);
        chk("areset_rob",    {27'd0, rob_o}, 32'd0);
        chk("areset_jump",   {31'd0, jump_o}, 32'd0);
        chk("areset_target", target_o, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out("post_reset_quiet", 1'b0, 32'd0, 5'd0);
        end
        issue(OP_ADDI, 32'd7, 32'd0, 32'h0, 32'd9, 5'd13);
        tick();
        chk_out("post_reset_op", 1'b1, 32'd16, 5'd13);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
